// File: rtl/apb_node_timeout.sv
// APB 1-to-NB_MASTER bridge node with range decode, decode-error response,
// per-transfer PREADY timeout with abort, and a saturating error counter.
module apb_node_timeout #(
    parameter int unsigned NB_MASTER      = 10,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
    input  logic                                pwrite_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    output logic [APB_DATA_WIDTH-1:0]           prdata_o,
    output logic                                pready_o,
    output logic                                pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic                                pwrite_o,
    output logic                                penable_o,
    output logic [NB_MASTER-1:0]                psel_o,
    input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                pready_i,
    input  logic [NB_MASTER-1:0]                pslverr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                timeout_o,
    output logic                                decerr_o,
    output logic [ERR_CNT_WIDTH-1:0]            err_cnt_o
);

    localparam int unsigned IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DECERR, RESP} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic [TO_W-1:0]     tcnt;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [NB_MASTER-1:0] hit_onehot;

    // Lowest matching port wins: later matches are ignored once hit is set.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int unsigned i = 0; i < NB_MASTER; i++) begin
            if (!hit &&
                paddr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit           = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx_q     <= '0;
            tcnt      <= '0;
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            penable_o <= 1'b0;
            psel_o    <= '0;
            timeout_o <= 1'b0;
            decerr_o  <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        if (hit) begin
                            paddr_o  <= paddr_i;
                            pwdata_o <= pwdata_i;
                            pwrite_o <= pwrite_i;
                            idx_q    <= hit_idx;
                            psel_o   <= hit_onehot;
                            state    <= SETUP;
                        end else begin
                            decerr_o <= 1'b1;
                            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                            state    <= DECERR;
                        end
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    tcnt      <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i[idx_q]) begin
                        prdata_o  <= prdata_i[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        pslverr_o <= pslverr_i[idx_q];
                        pready_o  <= 1'b1;
                        psel_o    <= '0;
                        penable_o <= 1'b0;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && tcnt == TO_LAST) begin
                        prdata_o  <= '0;
                        pslverr_o <= 1'b1;
                        pready_o  <= 1'b1;
                        psel_o    <= '0;
                        penable_o <= 1'b0;
                        timeout_o <= 1'b1;
                        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DECERR: begin
                    decerr_o  <= 1'b0;
                    prdata_o  <= '0;
                    pslverr_o <= 1'b1;
                    pready_o  <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    prdata_o  <= '0;
                    pslverr_o <= 1'b0;
                    pready_o  <= 1'b0;
                    timeout_o <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_node_timeout.sv
// Scoreboard bench for apb_node_timeout: directed transfers push expected
// downstream setups and upstream responses; a monitor pops and compares.
module tb_apb_node_timeout;

    localparam int unsigned NB = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam int unsigned EW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [AW-1:0]     paddr_i;
    logic [DW-1:0]     pwdata_i;
    logic              pwrite_i;
    logic              psel_i;
    logic              penable_i;
    logic [DW-1:0]     prdata_o;
    logic              pready_o;
    logic              pslverr_o;
    logic [AW-1:0]     paddr_o;
    logic [DW-1:0]     pwdata_o;
    logic              pwrite_o;
    logic              penable_o;
    logic [NB-1:0]     psel_o;
    logic [NB*DW-1:0]  prdata_i;
    logic [NB-1:0]     pready_i;
    logic [NB-1:0]     pslverr_i;
    logic [NB*AW-1:0]  start_addr_i;
    logic [NB*AW-1:0]  end_addr_i;
    logic              timeout_o;
    logic              decerr_o;
    logic [EW-1:0]     err_cnt_o;

    always #5 clk_i = ~clk_i;

    apb_node_timeout #(
        .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .penable_o(penable_o), .psel_o(psel_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .timeout_o(timeout_o), .decerr_o(decerr_o), .err_cnt_o(err_cnt_o)
    );

    typedef struct {
        logic [NB-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        int            t0;
    } dn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        logic          to;
        logic          de;
        logic [EW-1:0] cnt;
        int            t0;
    } rs_t;

    dn_t dq[$];
    rs_t rq[$];
    dn_t cur;
    rs_t got;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    logic [EW-1:0] exp_cnt = '0;
    logic prev_de = 1'b0;

    logic [AW-1:0]   st_tab [NB];
    logic [AW-1:0]   en_tab [NB];
    logic [DW-1:0]   rd_cfg [NB];
    int unsigned     wait_cfg [NB];
    logic [NB-1:0]   hang;
    logic [NB-1:0]   err_cfg;
    int unsigned     acc_cnt;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always_comb begin
        start_addr_i = '0;
        end_addr_i   = '0;
        prdata_i     = '0;
        for (int i = 0; i < NB; i++) begin
            start_addr_i[i*AW +: AW] = st_tab[i];
            end_addr_i[i*AW +: AW]   = en_tab[i];
            prdata_i[i*DW +: DW]     = rd_cfg[i];
        end
    end

    // Unselected slaves drive ready/error high so a wrong port index shows up.
    always_comb begin
        pready_i  = '1;
        pslverr_i = '1;
        for (int i = 0; i < NB; i++) begin
            if (psel_o[i]) begin
                pready_i[i]  = penable_o && !hang[i] && (acc_cnt == wait_cfg[i]);
                pslverr_i[i] = err_cfg[i];
            end
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc_cnt <= 0;
        else if (penable_o && |(psel_o & ~pready_i)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (|psel_o && !penable_o) begin
                if (dq.size() == 0) chk("unexp_setup", 64'(psel_o), 64'(0));
                else begin
                    cur = dq.pop_front();
                    chk("setup_sel",   64'(psel_o),   64'(cur.sel));
                    chk("setup_addr",  64'(paddr_o),  64'(cur.addr));
                    chk("setup_wdata", 64'(pwdata_o), 64'(cur.wdata));
                    chk("setup_wr",    64'(pwrite_o), 64'(cur.wr));
                    chk("setup_lat",   64'(cyc - cur.t0), 64'(1));
                end
            end else if (|psel_o && penable_o) begin
                chk("acc_sel",   64'(psel_o),   64'(cur.sel));
                chk("acc_addr",  64'(paddr_o),  64'(cur.addr));
                chk("acc_wdata", 64'(pwdata_o), 64'(cur.wdata));
                chk("acc_wr",    64'(pwrite_o), 64'(cur.wr));
            end
            if (pready_o) begin
                if (rq.size() == 0) chk("unexp_resp", 64'(pready_o), 64'(0));
                else begin
                    got = rq.pop_front();
                    chk("resp_rdata", 64'(prdata_o),  64'(got.rdata));
                    chk("resp_err",   64'(pslverr_o), 64'(got.err));
                    chk("resp_lat",   64'(cyc - got.t0), 64'(got.lat));
                    chk("resp_tmo",   64'(timeout_o), 64'(got.to));
                    chk("decerr_pre", 64'(prev_de),   64'(got.de));
                    chk("decerr_now", 64'(decerr_o),  64'(0));
                    chk("resp_cnt",   64'(err_cnt_o), 64'(got.cnt));
                    chk("resp_psel",  64'(psel_o),    64'(0));
                end
            end
            prev_de = decerr_o;
        end
    end

    task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic wr,
                        input int port, input logic [DW-1:0] exp_rd, input logic exp_err,
                        input int exp_lat, input logic exp_to);
        dn_t d;
        rs_t r;
        @(negedge clk_i);
        if (port < 0 || exp_to) begin
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
        if (port >= 0) begin
            d.sel = NB'(1) << port; d.addr = addr; d.wdata = wdata; d.wr = wr; d.t0 = cyc;
            dq.push_back(d);
        end
        r.rdata = exp_rd; r.err = exp_err; r.lat = exp_lat; r.to = exp_to;
        r.de = (port < 0); r.cnt = exp_cnt; r.t0 = cyc;
        rq.push_back(r);
        paddr_i = addr; pwdata_i = wdata; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        for (int n = 0; n < 40 && !pready_o; n++) @(negedge clk_i);
        chk("resp_wait", 64'(pready_o), 64'(1));
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        st_tab = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_2000, 32'h1A10_6000,
                   32'h1A10_4000, 32'h1A10_5000, 32'h2000_0000, 32'h3000_0000};
        en_tab = '{32'h1A10_0FFF, 32'h1A10_1FFF, 32'h1A10_2FFF, 32'h1A10_6FFF,
                   32'h1A10_4FFF, 32'h1A10_6FFF, 32'h2000_FFFF, 32'h3000_FFFF};
        for (int i = 0; i < NB; i++) begin
            rd_cfg[i]   = 32'hA0A0_0000 + DW'(i);
            wait_cfg[i] = 0;
        end
        rd_cfg[1] = 32'h1234_5678;
        hang = '0; err_cfg = '0;
        paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;

        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #3;
        chk("rst_psel",    64'(psel_o),    64'(0));
        chk("rst_penable", 64'(penable_o), 64'(0));
        chk("rst_pready",  64'(pready_o),  64'(0));
        chk("rst_pslverr", 64'(pslverr_o), 64'(0));
        chk("rst_prdata",  64'(prdata_o),  64'(0));
        chk("rst_paddr",   64'(paddr_o),   64'(0));
        chk("rst_tmo",     64'(timeout_o), 64'(0));
        chk("rst_decerr",  64'(decerr_o),  64'(0));
        chk("rst_cnt",     64'(err_cnt_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        xfer(32'h1A10_1004, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0, 3, 1'b0);
        // Three wait states: ready lands in the last allowed ACCESS cycle.
        wait_cfg[0] = 3;
        xfer(32'h1A10_0010, 32'hCAFE_F00D, 1'b1, 0, 32'hA0A0_0000, 1'b0, 6, 1'b0);
        xfer(32'h0000_0000, 32'h0, 1'b0, -1, 32'h0, 1'b1, 2, 1'b0);
        hang[2] = 1'b1;
        xfer(32'h1A10_2000, 32'h5555_AAAA, 1'b1, 2, 32'h0, 1'b1, 6, 1'b1);
        hang[2] = 1'b0;
        xfer(32'h1A10_2FFC, 32'h0, 1'b0, 2, 32'hA0A0_0002, 1'b0, 3, 1'b0);
        xfer(32'h1A10_1FFF, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0, 3, 1'b0);
        xfer(32'h1A10_6000, 32'h0, 1'b0, 3, 32'hA0A0_0003, 1'b0, 3, 1'b0);
        xfer(32'h1A10_5800, 32'h0, 1'b0, 5, 32'hA0A0_0005, 1'b0, 3, 1'b0);
        err_cfg[4] = 1'b1;
        xfer(32'h1A10_4100, 32'h0, 1'b0, 4, 32'hA0A0_0004, 1'b1, 3, 1'b0);
        xfer(32'h1A10_7000, 32'h0, 1'b0, -1, 32'h0, 1'b1, 2, 1'b0);
        xfer(32'hFFFF_FFFF, 32'h0, 1'b0, -1, 32'h0, 1'b1, 2, 1'b0);
        xfer(32'h1A0F_FFFF, 32'h0, 1'b0, -1, 32'h0, 1'b1, 2, 1'b0);
        xfer(32'h0000_0000, 32'h0, 1'b1, -1, 32'h0, 1'b1, 2, 1'b0);
        xfer(32'h4000_0000, 32'h0, 1'b0, -1, 32'h0, 1'b1, 2, 1'b0);
        chk("cnt_saturated", 64'(err_cnt_o), 64'(3));
        wait_cfg[6] = 2;
        xfer(32'h2000_FFFF, 32'h0BAD_BEEF, 1'b1, 6, 32'hA0A0_0006, 1'b0, 5, 1'b0);

        // Reset in the first ACCESS cycle: transfer is dropped, no response.
        wait_cfg[1] = 10;
        @(negedge clk_i);
        cur.sel = NB'(2); cur.addr = 32'h1A10_1100; cur.wdata = '0; cur.wr = 1'b0; cur.t0 = cyc;
        dq.push_back(cur);
        paddr_i = 32'h1A10_1100; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        for (int n = 0; n < 20 && !penable_o; n++) @(negedge clk_i);
        chk("rst_reach_acc", 64'(penable_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_psel",    64'(psel_o),    64'(0));
        chk("midrst_penable", 64'(penable_o), 64'(0));
        chk("midrst_pready",  64'(pready_o),  64'(0));
        chk("midrst_cnt",     64'(err_cnt_o), 64'(0));
        psel_i = 1'b0; penable_i = 1'b0;
        exp_cnt = '0;
        wait_cfg[1] = 0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;

        xfer(32'h3000_0040, 32'h0, 1'b0, 7, 32'hA0A0_0007, 1'b0, 3, 1'b0);

        repeat (4) @(negedge clk_i);
        chk("dq_empty", 64'(dq.size()), 64'(0));
        chk("rq_empty", 64'(rq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
